// File: rtl/mt_opmon_pkg.sv
// Shared types and widths for the MT operation monitor.
package mt_opmon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      POS  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam int OPI_W = 24;
   localparam int DTE_W = 16;
   localparam int FC_W  = 16;

endpackage

// File: rtl/mt_opmon_timer.sv
// Saturating up-counter with clear; flags the cycle it steps onto limit and
// holds 'reached' while parked there.
module mt_opmon_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         expire,
   output logic         reached
);

   logic [W-1:0] count_reg;

   assign reached = (count_reg == limit);
   assign expire  = inc && !clr && !reached && (count_reg == limit - W'(1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_reg <= '0;
      end else if (inc && !reached) begin
         count_reg <= count_reg + W'(1);
      end
   end

endmodule

// File: rtl/mt_opmon.sv
// MT operation monitor: frame counter plus OPI/FCE/DTE set strobes and done/busy.
// Build option: define MT_DTE_CHECK_EN to include the drive timing error check.
module mt_opmon
   import mt_opmon_pkg::*;
#(
   parameter logic [OPI_W-1:0] OPI_TIMEOUT = 24'd5000000,
   parameter logic [DTE_W-1:0] DTE_WINDOW  = 16'd2000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mtINIT,
   input  logic            mtGO,
   input  logic            mtXFER,
   input  logic            mtWRITE,
   input  logic [FC_W-1:0] mtFCIN,
   input  logic            slvFRAME,
   input  logic            slvEOR,
   output logic [FC_W-1:0] mtFC,
   output logic            mtBUSY,
   output logic            mtDONE,
   output logic            mtSETOPI,
   output logic            mtSETFCE,
   output logic            mtSETDTE
);

   state_t          state_reg, state_next;
   logic [FC_W-1:0] fc_reg, fc_next;
   logic            full_reg, full_next;      // loaded count of 0 stands for 65536
   logic            write_reg, write_next;
   logic            fce_fired_reg, fce_fired_next;
   logic            busy_reg, done_reg, setopi_reg, setfce_reg;
   logic            fce_hit, opi_hit, go_accept;
   logic            opi_expire, opi_reached;
   logic            srst;

   assign srst = rst || mtINIT;

   mt_opmon_timer #(.W(OPI_W)) u_opi_timer (
      .clk     (clk),
      .rst     (srst),
      .clr     (go_accept),
      .inc     ((state_reg == XFER) || (state_reg == POS)),
      .limit   (OPI_TIMEOUT),
      .expire  (opi_expire),
      .reached (opi_reached)
   );

   always_comb begin
      state_next     = state_reg;
      fc_next        = fc_reg;
      full_next      = full_reg;
      write_next     = write_reg;
      fce_fired_next = fce_fired_reg;
      fce_hit        = 1'b0;
      opi_hit        = 1'b0;
      go_accept      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mtGO) begin
               go_accept      = 1'b1;
               fc_next        = mtFCIN;
               full_next      = (mtFCIN == '0);
               write_next     = mtXFER && mtWRITE;
               fce_fired_next = 1'b0;
               state_next     = mtXFER ? XFER : POS;
            end
         end
         XFER, POS: begin
            if ((state_reg == XFER) && slvFRAME) begin
               if ((fc_reg == '0) && !full_reg) fce_hit = 1'b1;
               fc_next   = fc_reg - 16'd1;
               full_next = 1'b0;
            end
            // The frame is counted first, so EOR sees the post-decrement count.
            if (slvEOR) begin
               state_next = FIN;
               if (write_reg && ((fc_next != '0) || full_next)) fce_hit = 1'b1;
            end else if (opi_reached) begin
               state_next = FIN;
            end else if (opi_expire) begin
               opi_hit = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (fce_hit) fce_fired_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg     <= IDLE;
         fc_reg        <= '0;
         full_reg      <= 1'b0;
         write_reg     <= 1'b0;
         fce_fired_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         setopi_reg    <= 1'b0;
         setfce_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         fc_reg        <= fc_next;
         full_reg      <= full_next;
         write_reg     <= write_next;
         fce_fired_reg <= fce_fired_next;
         busy_reg      <= (state_next == XFER) || (state_next == POS);
         done_reg      <= (state_next == FIN);
         setopi_reg    <= opi_hit;
         setfce_reg    <= fce_hit && !fce_fired_reg;
      end
   end

   assign mtFC     = fc_reg;
   assign mtBUSY   = busy_reg;
   assign mtDONE   = done_reg;
   assign mtSETOPI = setopi_reg;
   assign mtSETFCE = setfce_reg;

`ifdef MT_DTE_CHECK_EN
   logic seen_reg, dte_fired_reg, setdte_reg;
   logic dte_clr, dte_inc, dte_expire, dte_reached;

   assign dte_clr = go_accept || ((state_reg == XFER) && slvFRAME);
   assign dte_inc = (state_reg == XFER) && seen_reg && !slvFRAME;

   mt_opmon_timer #(.W(DTE_W)) u_dte_timer (
      .clk     (clk),
      .rst     (srst),
      .clr     (dte_clr),
      .inc     (dte_inc),
      .limit   (DTE_WINDOW),
      .expire  (dte_expire),
      .reached (dte_reached)
   );

   always_ff @(posedge clk) begin
      if (srst) begin
         seen_reg      <= 1'b0;
         dte_fired_reg <= 1'b0;
         setdte_reg    <= 1'b0;
      end else begin
         setdte_reg <= dte_expire && !dte_fired_reg && !dte_reached;
         if (go_accept) begin
            seen_reg      <= 1'b0;
            dte_fired_reg <= 1'b0;
         end else begin
            if ((state_reg == XFER) && slvFRAME) seen_reg <= 1'b1;
            if (dte_expire) dte_fired_reg <= 1'b1;
         end
      end
   end

   assign mtSETDTE = setdte_reg;
`else
   assign mtSETDTE = 1'b0;
`endif

endmodule

// File: tb/tb_mt_opmon.sv
// Directed self-checking bench for mt_opmon (OPI_TIMEOUT=100, DTE_WINDOW=10).
module tb_mt_opmon;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mtINIT = 1'b0;
   logic        mtGO = 1'b0;
   logic        mtXFER = 1'b0;
   logic        mtWRITE = 1'b0;
   logic [15:0] mtFCIN = 16'd0;
   logic        slvFRAME = 1'b0;
   logic        slvEOR = 1'b0;
   logic [15:0] mtFC;
   logic        mtBUSY, mtDONE, mtSETOPI, mtSETFCE, mtSETDTE;

   int checks = 0;
   int failures = 0;

`ifdef MT_DTE_CHECK_EN
   localparam int DTE_EXP = 1;
`else
   localparam int DTE_EXP = 0;
`endif

   always #5 clk = ~clk;

   mt_opmon #(.OPI_TIMEOUT(24'd100), .DTE_WINDOW(16'd10)) dut (
      .clk      (clk),
      .rst      (rst),
      .mtINIT   (mtINIT),
      .mtGO     (mtGO),
      .mtXFER   (mtXFER),
      .mtWRITE  (mtWRITE),
      .mtFCIN   (mtFCIN),
      .slvFRAME (slvFRAME),
      .slvEOR   (slvEOR),
      .mtFC     (mtFC),
      .mtBUSY   (mtBUSY),
      .mtDONE   (mtDONE),
      .mtSETOPI (mtSETOPI),
      .mtSETFCE (mtSETFCE),
      .mtSETDTE (mtSETDTE)
   );

   // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge.
   task automatic step(input logic go, input logic xfer, input logic wr, input logic [15:0] fcin,
                       input logic frame, input logic eor, input logic init);
      @(negedge clk);
      mtGO = go; mtXFER = xfer; mtWRITE = wr; mtFCIN = fcin;
      slvFRAME = frame; slvEOR = eor; mtINIT = init;
      @(posedge clk);
      #1;
      $display("step go=%0b xfer=%0b wr=%0b fcin=%0d frame=%0b eor=%0b init=%0b -> fc=%h busy=%0b done=%0b opi=%0b fce=%0b dte=%0b",
               go, xfer, wr, fcin, frame, eor, init, mtFC, mtBUSY, mtDONE, mtSETOPI, mtSETFCE, mtSETDTE);
   endtask

   task automatic tick(input logic frame, input logic eor);
      step(1'b0, 1'b0, 1'b0, 16'd0, frame, eor, 1'b0);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mtFC, mtBUSY, mtDONE, mtSETOPI, mtSETFCE, mtSETDTE} !== 21'd0) begin
         failures++;
         $display("FAIL reset_state got fc=%h busy=%0b done=%0b opi=%0b fce=%0b dte=%0b want all 0",
                  mtFC, mtBUSY, mtDONE, mtSETOPI, mtSETFCE, mtSETDTE);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_exact;
      int fce_cnt = 0;
      step(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mtBUSY !== 1'b1 || mtFC !== 16'd4) begin
         failures++;
         $display("FAIL go_load got busy=%0b fc=%h want busy=1 fc=0004", mtBUSY, mtFC);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0);
         fce_cnt += int'(mtSETFCE);
      end
      checks++;
      if (mtFC !== 16'd0 || mtDONE !== 1'b0) begin
         failures++;
         $display("FAIL write_exact_count got fc=%h done=%0b want fc=0000 done=0", mtFC, mtDONE);
      end
      tick(1'b0, 1'b1);
      fce_cnt += int'(mtSETFCE);
      checks++;
      if (mtDONE !== 1'b1 || mtBUSY !== 1'b0 || fce_cnt != 0 || mtSETOPI !== 1'b0) begin
         failures++;
         $display("FAIL write_exact_done got done=%0b busy=%0b fce_pulses=%0d opi=%0b want done=1 busy=0 fce_pulses=0 opi=0",
                  mtDONE, mtBUSY, fce_cnt, mtSETOPI);
      end
      // GO presented during the FIN cycle must be ignored.
      step(1'b1, 1'b1, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mtDONE !== 1'b0 || mtBUSY !== 1'b0 || mtFC !== 16'd0) begin
         failures++;
         $display("FAIL go_in_fin got done=%0b busy=%0b fc=%h want done=0 busy=0 fc=0000", mtDONE, mtBUSY, mtFC);
      end
   endtask

   task automatic test_write_short;
      step(1'b1, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      checks++;
      if (mtSETFCE !== 1'b1 || mtFC !== 16'd1 || mtDONE !== 1'b1) begin
         failures++;
         $display("FAIL write_short got fce=%0b fc=%h done=%0b want fce=1 fc=0001 done=1", mtSETFCE, mtFC, mtDONE);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (mtSETFCE !== 1'b0 || mtDONE !== 1'b0) begin
         failures++;
         $display("FAIL write_short_once got fce=%0b done=%0b want fce=0 done=0", mtSETFCE, mtDONE);
      end
   endtask

   task automatic test_read_fce;
      step(1'b1, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      checks++;
      if (mtSETFCE !== 1'b0 || mtFC !== 16'd0) begin
         failures++;
         $display("FAIL read_two_frames got fce=%0b fc=%h want fce=0 fc=0000", mtSETFCE, mtFC);
      end
      tick(1'b1, 1'b0);
      checks++;
      if (mtSETFCE !== 1'b1 || mtFC !== 16'hFFFF) begin
         failures++;
         $display("FAIL read_overrun got fce=%0b fc=%h want fce=1 fc=ffff", mtSETFCE, mtFC);
      end
      tick(1'b1, 1'b1);
      checks++;
      if (mtSETFCE !== 1'b0 || mtFC !== 16'hFFFE || mtDONE !== 1'b1) begin
         failures++;
         $display("FAIL read_overrun_once got fce=%0b fc=%h done=%0b want fce=0 fc=fffe done=1", mtSETFCE, mtFC, mtDONE);
      end
      tick(1'b0, 1'b0);
      // Short read record: one frame plus EOR in the same cycle.
      step(1'b1, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1);
      checks++;
      if (mtSETFCE !== 1'b0 || mtFC !== 16'd4 || mtDONE !== 1'b1) begin
         failures++;
         $display("FAIL read_short got fce=%0b fc=%h done=%0b want fce=0 fc=0004 done=1", mtSETFCE, mtFC, mtDONE);
      end
      tick(1'b0, 1'b0);
      // Write where the last frame coincides with EOR: exact count, no FCE.
      step(1'b1, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1);
      checks++;
      if (mtSETFCE !== 1'b0 || mtFC !== 16'd0 || mtDONE !== 1'b1) begin
         failures++;
         $display("FAIL frame_with_eor got fce=%0b fc=%h done=%0b want fce=0 fc=0000 done=1", mtSETFCE, mtFC, mtDONE);
      end
      tick(1'b0, 1'b0);
   endtask

   task automatic test_opi;
      int early = 0;
      step(1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 100; i++) begin
         tick(1'b1, 1'b0);
         early += int'(mtSETOPI) + int'(mtDONE);
      end
      checks++;
      if (early != 0 || mtFC !== 16'd3) begin
         failures++;
         $display("FAIL opi_early got early_pulses=%0d fc=%h want early_pulses=0 fc=0003", early, mtFC);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (mtSETOPI !== 1'b1 || mtDONE !== 1'b0 || mtBUSY !== 1'b1) begin
         failures++;
         $display("FAIL opi_pulse got opi=%0b done=%0b busy=%0b want opi=1 done=0 busy=1", mtSETOPI, mtDONE, mtBUSY);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (mtSETOPI !== 1'b0 || mtDONE !== 1'b1 || mtBUSY !== 1'b0) begin
         failures++;
         $display("FAIL opi_done got opi=%0b done=%0b busy=%0b want opi=0 done=1 busy=0", mtSETOPI, mtDONE, mtBUSY);
      end
      tick(1'b0, 1'b0);
      // EOR arriving in the timeout cycle wins.
      step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 100; i++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      checks++;
      if (mtSETOPI !== 1'b0 || mtDONE !== 1'b1) begin
         failures++;
         $display("FAIL opi_eor_tie got opi=%0b done=%0b want opi=0 done=1", mtSETOPI, mtDONE);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (mtSETOPI !== 1'b0 || mtDONE !== 1'b0) begin
         failures++;
         $display("FAIL opi_eor_tie_after got opi=%0b done=%0b want opi=0 done=0", mtSETOPI, mtDONE);
      end
   endtask

   task automatic test_dte;
      int pulses = 0;
      int at_ten = 0;
      step(1'b1, 1'b1, 1'b0, 16'd20, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         tick(1'b0, 1'b0);
         pulses += int'(mtSETDTE);
         if (i == 10) at_ten = int'(mtSETDTE);
      end
      checks++;
      if (pulses != DTE_EXP || at_ten != DTE_EXP) begin
         failures++;
         $display("FAIL dte_gap got pulses=%0d pulse_at_10=%0d want pulses=%0d pulse_at_10=%0d",
                  pulses, at_ten, DTE_EXP, DTE_EXP);
      end
      tick(1'b0, 1'b1);
      checks++;
      if (mtDONE !== 1'b1 || mtSETFCE !== 1'b0 || mtFC !== 16'd19) begin
         failures++;
         $display("FAIL dte_finish got done=%0b fce=%0b fc=%h want done=1 fce=0 fc=0013", mtDONE, mtSETFCE, mtFC);
      end
      tick(1'b0, 1'b0);
   endtask

   task automatic test_init_and_busy_go;
      step(1'b1, 1'b1, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'd99, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mtFC !== 16'd7 || mtBUSY !== 1'b1) begin
         failures++;
         $display("FAIL go_while_busy got fc=%h busy=%0b want fc=0007 busy=1", mtFC, mtBUSY);
      end
      step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (mtFC !== 16'd0 || mtBUSY !== 1'b0 || mtDONE !== 1'b0 || mtSETFCE !== 1'b0 || mtSETOPI !== 1'b0) begin
         failures++;
         $display("FAIL init_mid_xfer got fc=%h busy=%0b done=%0b fce=%0b opi=%0b want fc=0000 busy=0 done=0 fce=0 opi=0",
                  mtFC, mtBUSY, mtDONE, mtSETFCE, mtSETOPI);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (mtDONE !== 1'b0 || mtBUSY !== 1'b0) begin
         failures++;
         $display("FAIL init_after got done=%0b busy=%0b want done=0 busy=0", mtDONE, mtBUSY);
      end
   endtask

   initial begin
      test_reset;
      test_write_exact;
      test_write_short;
      test_read_fce;
      test_opi;
      test_dte;
      test_init_and_busy_go;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
